// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default word width, GPR addressing and
// the architecturally named register indices.
package mips_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH     = 5;
  localparam int unsigned NUM_GPRS           = 32;

  // Named register indices
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

endpackage : mips_pkg

// File: rtl/register_file_read_port.sv
// One read port of the register file: $zero check, write-to-read bypass,
// entry select and an optional output register.
//
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   entries                flattened view of the whole entry array
//   write_enable/addr/data the write port, used only for bypass
//   read_addr              source entry
//   read_data              port value (combinational or registered)
module register_file_read_port
  import mips_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned  NUM_REGS     = NUM_GPRS,
  parameter bit           ZERO_REG     = 1'b1,
  parameter bit           BYPASS       = 1'b1,
  parameter int unsigned  READ_LATENCY = 0,
  localparam int unsigned ADDR_WIDTH   = $clog2(NUM_REGS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] entries,
  input  logic                               write_enable,
  input  logic [ADDR_WIDTH-1:0]              write_addr,
  input  logic [DATA_WIDTH-1:0]              write_data,
  input  logic [ADDR_WIDTH-1:0]              read_addr,
  output logic [DATA_WIDTH-1:0]              read_data
);

  logic [DATA_WIDTH-1:0] read_value_c;
  logic [DATA_WIDTH-1:0] read_q;

  // Port value before the output register; $zero wins over bypass.
  always_comb begin
    read_value_c = entries[read_addr];
    if (ZERO_REG && (read_addr == ADDR_WIDTH'(REG_ZERO))) begin
      read_value_c = '0;
    end else if (BYPASS && write_enable && (read_addr == write_addr)) begin
      read_value_c = write_data;
    end
  end

  // Output register; free-running load, pruned when READ_LATENCY = 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_q <= '0;
    end else begin
      read_q <= read_value_c;
    end
  end

  assign read_data = (READ_LATENCY == 0) ? read_value_c : read_q;

endmodule : register_file_read_port

// File: rtl/register_file.sv
// Two-read / one-write register file for the MIPS decode stage, with
// optional hardwired $zero, write-to-read bypass and registered reads.
//
// Ports:
//   clock         rising-edge clock
//   reset         async active-low; clears entries and read registers
//   write_enable  commit write_data to write_addr on the rising edge
//   write_addr    destination entry
//   write_data    value to store
//   read_addr_a/b source entries for ports A and B
//   read_data_a/b port values
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned  NUM_REGS     = NUM_GPRS,
  parameter bit           ZERO_REG     = 1'b1,
  parameter bit           BYPASS       = 1'b1,
  parameter int unsigned  READ_LATENCY = 0,
  localparam int unsigned ADDR_WIDTH   = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] entries;
  logic                                write_commit_c;

  // Writes to $zero are dropped so entry 0 stays at its reset value.
  assign write_commit_c = write_enable &&
                          !(ZERO_REG && (write_addr == ADDR_WIDTH'(REG_ZERO)));

  // Entry array and write decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries <= '0;
    end else if (write_commit_c) begin
      entries[write_addr] <= write_data;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .ZERO_REG     (ZERO_REG),
    .BYPASS       (BYPASS),
    .READ_LATENCY (READ_LATENCY)
  ) u_port_a (
    .clock        (clock),
    .reset        (reset),
    .entries      (entries),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_addr    (read_addr_a),
    .read_data    (read_data_a)
  );

  register_file_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .ZERO_REG     (ZERO_REG),
    .BYPASS       (BYPASS),
    .READ_LATENCY (READ_LATENCY)
  ) u_port_b (
    .clock        (clock),
    .reset        (reset),
    .entries      (entries),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_addr    (read_addr_b),
    .read_data    (read_data_b)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Bench for register_file: four configurations share one stimulus stream
// and are compared against an array-based model of the read/write rules.
module tb_register_file;
  import mips_pkg::*;

  localparam int NCFG = 4;
  // u0: default; u1: no $zero, no bypass; u2: registered read; u3: 8x16
  localparam bit          ZERO_CFG  [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit          BYP_CFG   [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam int          LAT_CFG   [NCFG] = '{0, 0, 1, 1};
  localparam int          NREGS_CFG [NCFG] = '{32, 32, 32, 8};
  localparam logic [31:0] MASK_CFG  [NCFG] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                               32'hFFFF_FFFF, 32'h0000_FFFF};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [4:0]  wa    = '0;
  logic [31:0] wd    = '0;
  logic [4:0]  ra    = '0;
  logic [4:0]  rb    = '0;

  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;
  logic [15:0] rd_a3, rd_b3;
  logic [31:0] obs_a [NCFG];
  logic [31:0] obs_b [NCFG];

  int checks = 0;
  int passed = 0;

  // Model state
  logic [31:0] mem   [NCFG][32];
  logic [31:0] lat_a [NCFG];
  logic [31:0] lat_b [NCFG];

  always #5 clock = ~clock;

  register_file #(.DATA_WIDTH(32), .NUM_REGS(NREGS_CFG[0]), .ZERO_REG(ZERO_CFG[0]),
                  .BYPASS(BYP_CFG[0]), .READ_LATENCY(LAT_CFG[0])) u0 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_addr_a(ra), .read_addr_b(rb), .read_data_a(rd_a0), .read_data_b(rd_b0));

  register_file #(.DATA_WIDTH(32), .NUM_REGS(NREGS_CFG[1]), .ZERO_REG(ZERO_CFG[1]),
                  .BYPASS(BYP_CFG[1]), .READ_LATENCY(LAT_CFG[1])) u1 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_addr_a(ra), .read_addr_b(rb), .read_data_a(rd_a1), .read_data_b(rd_b1));

  register_file #(.DATA_WIDTH(32), .NUM_REGS(NREGS_CFG[2]), .ZERO_REG(ZERO_CFG[2]),
                  .BYPASS(BYP_CFG[2]), .READ_LATENCY(LAT_CFG[2])) u2 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_addr_a(ra), .read_addr_b(rb), .read_data_a(rd_a2), .read_data_b(rd_b2));

  register_file #(.DATA_WIDTH(16), .NUM_REGS(NREGS_CFG[3]), .ZERO_REG(ZERO_CFG[3]),
                  .BYPASS(BYP_CFG[3]), .READ_LATENCY(LAT_CFG[3])) u3 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(wa[2:0]),
    .write_data(wd[15:0]), .read_addr_a(ra[2:0]), .read_addr_b(rb[2:0]),
    .read_data_a(rd_a3), .read_data_b(rd_b3));

  assign obs_a[0] = rd_a0;
  assign obs_b[0] = rd_b0;
  assign obs_a[1] = rd_a1;
  assign obs_b[1] = rd_b1;
  assign obs_a[2] = rd_a2;
  assign obs_b[2] = rd_b2;
  assign obs_a[3] = 32'(rd_a3);
  assign obs_b[3] = 32'(rd_b3);

  // Read rule: $zero first, then same-cycle bypass, else stored word.
  function automatic logic [31:0] model_read(int k, logic [4:0] addr);
    int a = int'(addr) % NREGS_CFG[k];
    int w = int'(wa) % NREGS_CFG[k];
    if (ZERO_CFG[k] && a == 0) return '0;
    if (BYP_CFG[k] && we && a == w) return wd & MASK_CFG[k];
    return mem[k][a];
  endfunction

  // Rising edge with reset high: registered ports capture, then write lands.
  task automatic model_edge();
    for (int k = 0; k < NCFG; k++) begin
      logic [31:0] na = model_read(k, ra);
      logic [31:0] nb = model_read(k, rb);
      int w = int'(wa) % NREGS_CFG[k];
      if (we && !(ZERO_CFG[k] && w == 0)) mem[k][w] = wd & MASK_CFG[k];
      lat_a[k] = na;
      lat_b[k] = nb;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      for (int i = 0; i < 32; i++) mem[k][i] = '0;
      lat_a[k] = '0;
      lat_b[k] = '0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NCFG; k++) begin
      logic [31:0] ea = (LAT_CFG[k] != 0) ? lat_a[k] : model_read(k, ra);
      logic [31:0] eb = (LAT_CFG[k] != 0) ? lat_b[k] : model_read(k, rb);
      check($sformatf("%s_u%0d_a", tag, k), obs_a[k], ea);
      check($sformatf("%s_u%0d_b", tag, k), obs_b[k], eb);
    end
  endtask

  // One cycle: drive on falling edge, check before and after the rising edge.
  task automatic step(input logic w_en, input logic [4:0] w_a, input logic [31:0] w_d,
                      input logic [4:0] r_a, input logic [4:0] r_b);
    @(negedge clock);
    we = w_en; wa = w_a; wd = w_d; ra = r_a; rb = r_b;
    #1;
    check_all("pre");
    @(posedge clock);
    if (reset) model_edge();
    #1;
    check_all("post");
  endtask

  initial begin
    model_reset();

    // Power-on reset
    #1 reset = 1'b0;
    model_reset();
    #2 check_all("rst_init");
    @(negedge clock) reset = 1'b1;

    // Every address reads 0 on both ports
    for (int i = 0; i < 32; i++) step(1'b0, '0, '0, 5'(i), 5'(31 - i));

    // r5 write, both ports read it
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
    check("r5_u0_a", rd_a0, 32'hDEAD_BEEF);
    check("r5_u2_b", rd_b2, 32'hDEAD_BEEF);
    step(1'b0, '0, '0, 5'd5, 5'd5);
    check("r5_u1_b", rd_b1, 32'hDEAD_BEEF);

    // Write to r0: dropped only where $zero is hardwired
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(1'b0, '0, '0, 5'd0, 5'd0);
    check("r0_u0_a", rd_a0, 32'h0);
    check("r0_u1_a", rd_a1, 32'hFFFF_FFFF);

    // r7 same-cycle write/read: bypass vs old contents
    step(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0);
    check("r7_u1_a", rd_a1, 32'h1234_5678);

    // Back-to-back writes to $ra seen on successive edges of the registered port
    step(1'b1, 5'(REG_RA), 32'h1, 5'd0, 5'(REG_RA));
    check("ra1_u2_b", rd_b2, 32'h1);
    step(1'b1, 5'(REG_RA), 32'h2, 5'd0, 5'(REG_RA));
    check("ra2_u2_b", rd_b2, 32'h2);
    step(1'b1, 5'(REG_RA), 32'h3, 5'd0, 5'(REG_RA));
    check("ra3_u2_b", rd_b2, 32'h3);

    // 8x16 instance: r7 written, r6 untouched
    step(1'b1, 5'd7, 32'h0000_A5A5, 5'd7, 5'd6);
    step(1'b0, '0, '0, 5'd7, 5'd6);
    check("r7_u3_a", 32'(rd_a3), 32'h0000_A5A5);
    check("r6_u3_b", 32'(rd_b3), 32'h0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [4:0] r_wa = 5'($urandom_range(0, 31));
      logic [4:0] r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), r_wa, $urandom, r_ra, 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-cycle with a write pending
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE_F00D; ra = 5'd9; rb = 5'd3;
    #1 reset = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    @(posedge clock);
    #1 check_all("rst_held");
    @(negedge clock) begin
      reset = 1'b1;
      we = 1'b0;
    end
    for (int i = 0; i < 32; i++) step(1'b0, '0, '0, 5'(i), 5'(i ^ 5'd31));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_register_file
